// File: rtl/snoop_responder.sv
// snoop_responder: L2 bus-side snoop responder (lookup, HIT/HITM/NoHIT, Modified-line writeback, MESI update)
// Ports:
//   snoop_valid/ready/cmd/addr  : snooped bus op handshake from the shared bus
//   tag_req/index, tag_hit/way/state : tag/state array lookup (result 1 cycle after tag_req)
//   result_valid/snoop_result   : one-cycle snoop response strobe
//   wb_valid/ready/addr/data/last : line writeback stream to memory
//   data_rd_en/addr/data        : data array read port ({index, way, beat}, 1-cycle latency)
//   state_wr_en/way/val         : MESI state write port
//   protocol_error              : one-cycle strobe, Write/Invalidate snooped on our own M/E line
module snoop_responder #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 14,
    parameter int WAY_W      = 3,
    parameter int LINE_WORDS = 16,
    parameter int DATA_W     = 32,
    parameter logic [3:0] CMD_READ  = 4'h1,
    parameter logic [3:0] CMD_WRITE = 4'h2,
    parameter logic [3:0] CMD_RFO   = 4'h3,
    parameter logic [3:0] CMD_INV   = 4'h4,
    parameter logic [1:0] MESI_I = 2'd0,
    parameter logic [1:0] MESI_S = 2'd1,
    parameter logic [1:0] MESI_E = 2'd2,
    parameter logic [1:0] MESI_M = 2'd3,
    parameter logic [1:0] RES_NOHIT = 2'd0,
    parameter logic [1:0] RES_HIT   = 2'd1,
    parameter logic [1:0] RES_HITM  = 2'd2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        snoop_valid,
    output logic                                        snoop_ready,
    input  logic [3:0]                                  snoop_cmd,
    input  logic [ADDR_W-1:0]                           snoop_addr,
    output logic                                        tag_req,
    output logic [INDEX_W-1:0]                          tag_index,
    input  logic                                        tag_hit,
    input  logic [WAY_W-1:0]                            tag_way,
    input  logic [1:0]                                  tag_state,
    output logic                                        result_valid,
    output logic [1:0]                                  snoop_result,
    output logic                                        wb_valid,
    input  logic                                        wb_ready,
    output logic [ADDR_W-1:0]                           wb_addr,
    output logic [DATA_W-1:0]                           wb_data,
    output logic                                        wb_last,
    output logic                                        data_rd_en,
    output logic [INDEX_W+WAY_W+$clog2(LINE_WORDS)-1:0] data_rd_addr,
    input  logic [DATA_W-1:0]                           data_rd_data,
    output logic                                        state_wr_en,
    output logic [WAY_W-1:0]                            state_wr_way,
    output logic [1:0]                                  state_wr_val,
    output logic                                        protocol_error
);
    localparam int BEAT_W = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESPOND, S_WB, S_UPDATE} state_t;

    state_t              r_st, w_nxt;
    logic [3:0]          r_cmd;
    logic [ADDR_W-7:0]   r_line;
    logic                r_hit;
    logic [WAY_W-1:0]    r_way;
    logic [1:0]          r_mesi;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_pend;
    logic [DATA_W-1:0]   r_hold;
    logic [BEAT_W-1:0]   w_rd_beat;
    logic                w_acc;
    logic                w_hit;
    logic                w_rd, w_wr, w_rfo, w_inv;

    assign w_rd  = r_cmd == CMD_READ;
    assign w_wr  = r_cmd == CMD_WRITE;
    assign w_rfo = r_cmd == CMD_RFO;
    assign w_inv = r_cmd == CMD_INV;
    assign w_hit = r_hit && r_mesi != MESI_I;

    assign wb_valid     = r_st == S_WB;
    assign wb_last      = wb_valid && r_beat == BEAT_W'(LINE_WORDS - 1);
    assign w_acc        = wb_valid && wb_ready;
    assign wb_addr      = wb_valid ? {r_line, 6'b0} : '0;
    // Data arrives straight from the array the cycle after a read; while stalled it is replayed from r_hold.
    assign wb_data      = wb_valid ? (r_pend ? data_rd_data : r_hold) : '0;
    assign tag_index    = tag_req ? snoop_addr[INDEX_W+5:6] : '0;
    assign data_rd_addr = data_rd_en ? {r_line[INDEX_W-1:0], r_way, w_rd_beat} : '0;
    assign state_wr_way = state_wr_en ? r_way : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_st <= S_IDLE;
        else r_st <= w_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd  <= '0;
            r_line <= '0;
            r_hit  <= 1'b0;
            r_way  <= '0;
            r_mesi <= MESI_I;
            r_beat <= '0;
            r_pend <= 1'b0;
            r_hold <= '0;
        end else begin
            if (r_st == S_IDLE && snoop_valid) begin
                r_cmd  <= snoop_cmd;
                r_line <= snoop_addr[ADDR_W-1:6];
            end
            if (r_st == S_LOOKUP) begin
                r_hit  <= tag_hit;
                r_way  <= tag_way;
                r_mesi <= tag_state;
            end
            if (w_acc) r_beat <= wb_last ? '0 : r_beat + 1'b1;
            r_pend <= data_rd_en;
            if (r_pend) r_hold <= data_rd_data;
        end
    end

    always_comb begin
        w_nxt          = r_st;
        snoop_ready    = 1'b0;
        tag_req        = 1'b0;
        result_valid   = 1'b0;
        snoop_result   = RES_NOHIT;
        protocol_error = 1'b0;
        data_rd_en     = 1'b0;
        w_rd_beat      = '0;
        state_wr_en    = 1'b0;
        state_wr_val   = MESI_I;
        case (r_st)
            S_IDLE: begin
                snoop_ready = 1'b1;
                tag_req     = snoop_valid;
                w_nxt       = snoop_valid ? S_LOOKUP : S_IDLE;
            end
            S_LOOKUP: w_nxt = S_RESPOND;
            S_RESPOND: begin
                result_valid = 1'b1;
                if (!w_hit) begin
                    w_nxt = S_IDLE;
                end else if (r_mesi == MESI_M && (w_rd || w_rfo)) begin
                    // Prefetch beat 0 so the first writeback beat is ready on entry to S_WB.
                    snoop_result = RES_HITM;
                    data_rd_en   = 1'b1;
                    w_nxt        = S_WB;
                end else if ((r_mesi == MESI_M || r_mesi == MESI_E) && (w_wr || w_inv)) begin
                    snoop_result   = RES_HIT;
                    protocol_error = 1'b1;
                    w_nxt          = S_IDLE;
                end else begin
                    snoop_result = RES_HIT;
                    w_nxt        = S_UPDATE;
                end
            end
            S_WB: begin
                // Fetch the next beat in the accept cycle so back-to-back accepts have no bubbles.
                data_rd_en = w_acc && !wb_last;
                w_rd_beat  = r_beat + 1'b1;
                w_nxt      = (w_acc && wb_last) ? S_UPDATE : S_WB;
            end
            S_UPDATE: begin
                // Only S reaches here on Invalidate; Write on S keeps its state.
                state_wr_en  = w_rd || w_rfo || w_inv;
                state_wr_val = w_rd ? MESI_S : MESI_I;
                w_nxt        = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: scoreboard bench for snoop_responder
module tb_snoop_responder;
    localparam logic [3:0] C_RD = 4'h1, C_WR = 4'h2, C_RFO = 4'h3, C_INV = 4'h4;
    localparam logic [1:0] M_I = 2'd0, M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;
    localparam logic [1:0] R_NO = 2'd0, R_HIT = 2'd1, R_HITM = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snoop_valid = 1'b0;
    logic        snoop_ready;
    logic [3:0]  snoop_cmd = '0;
    logic [31:0] snoop_addr = '0;
    logic        tag_req;
    logic [13:0] tag_index;
    logic        tag_hit = 1'b0;
    logic [2:0]  tag_way = '0;
    logic [1:0]  tag_state = '0;
    logic        result_valid;
    logic [1:0]  snoop_result;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic        wb_last;
    logic        data_rd_en;
    logic [20:0] data_rd_addr;
    logic [31:0] data_rd_data = '0;
    logic        state_wr_en;
    logic [2:0]  state_wr_way;
    logic [1:0]  state_wr_val;
    logic        protocol_error;

    snoop_responder dut (
        .clk(clk), .reset(reset),
        .snoop_valid(snoop_valid), .snoop_ready(snoop_ready), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .tag_req(tag_req), .tag_index(tag_index), .tag_hit(tag_hit), .tag_way(tag_way), .tag_state(tag_state),
        .result_valid(result_valid), .snoop_result(snoop_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_last(wb_last),
        .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
        .state_wr_en(state_wr_en), .state_wr_way(state_wr_way), .state_wr_val(state_wr_val),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wb_acc = 0;
    logic tog = 1'b0;
    logic wb_ready_hold = 1'b1;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [2:0]  exp_res [$];
    logic [4:0]  exp_sw [$];
    logic [64:0] exp_wb [$];
    int          exp_busy [$];
    logic [13:0] exp_idx [$];

    function automatic logic [31:0] f(input logic [20:0] a);
        return 32'hC300_0000 | {11'b0, a};
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic unexp(input string n);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected_event required=none", n);
    endtask

    task automatic res(input logic [1:0] r, input logic p);
        exp_res.push_back({p, r});
    endtask

    task automatic sw(input logic [2:0] w, input logic [1:0] v);
        exp_sw.push_back({w, v});
    endtask

    task automatic line(input logic [31:0] a, input logic [2:0] w);
        for (int b = 0; b < 16; b++)
            exp_wb.push_back({b == 15, a[31:6], 6'b0, f({a[19:6], w, 4'(b)})});
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic h, input logic [2:0] w,
                         input logic [1:0] s, input int busy);
        int n;
        exp_idx.push_back(a[19:6]);
        exp_busy.push_back(busy);
        n = 0;
        while (!snoop_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_issue", 64'(snoop_ready), 64'd1);
        snoop_cmd = c; snoop_addr = a; tag_hit = h; tag_way = w; tag_state = s; snoop_valid = 1'b1;
        @(posedge clk); #1;
        snoop_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic h, input logic [2:0] w,
                         input logic [1:0] s, input int busy);
        int n;
        drive(c, a, h, w, s, busy);
        n = 0;
        while (!snoop_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("snoop_done", 64'(snoop_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        data_rd_data <= data_rd_en ? f(data_rd_addr) : 32'hDEAD_BEEF;
    end

    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk); #1;
            wb_ready = tog ? pat[k % 4] : wb_ready_hold;
            k++;
        end
    end

    initial begin
        logic prev_rdy, stall;
        logic [63:0] held_ad;
        logic held_last;
        logic [64:0] e;
        int acc_cyc, b;
        prev_rdy = 1'b1; stall = 1'b0; held_ad = '0; held_last = 1'b0; acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rdy = 1'b1;
                stall = 1'b0;
            end else begin
                if (tag_req) begin
                    if (exp_idx.size() == 0) unexp("tag_index");
                    else chk("tag_index", 64'(tag_index), 64'(exp_idx.pop_front()));
                end
                if (snoop_valid && snoop_ready) acc_cyc = cyc;
                if (result_valid) begin
                    chk("result_latency", 64'(cyc - acc_cyc), 64'd2);
                    if (exp_res.size() == 0) unexp("result");
                    else chk("result_perr", 64'({protocol_error, snoop_result}), 64'(exp_res.pop_front()));
                end else if (protocol_error) unexp("perr_stray");
                if (state_wr_en) begin
                    if (exp_sw.size() == 0) unexp("state_wr");
                    else chk("state_wr_way_val", 64'({state_wr_way, state_wr_val}), 64'(exp_sw.pop_front()));
                end
                if (stall) begin
                    chk("wb_hold_valid", 64'(wb_valid), 64'd1);
                    chk("wb_hold_addr_data", {wb_addr, wb_data}, held_ad);
                    chk("wb_hold_last", 64'(wb_last), 64'(held_last));
                end
                if (wb_valid && wb_ready) begin
                    wb_acc++;
                    if (exp_wb.size() == 0) unexp("wb_beat");
                    else begin
                        e = exp_wb.pop_front();
                        chk("wb_addr_data", {wb_addr, wb_data}, e[63:0]);
                        chk("wb_last", 64'(wb_last), 64'(e[64]));
                    end
                end
                stall = wb_valid && !wb_ready;
                held_ad = {wb_addr, wb_data};
                held_last = wb_last;
                if (snoop_ready && !prev_rdy) begin
                    if (exp_busy.size() == 0) unexp("busy");
                    else begin
                        b = exp_busy.pop_front();
                        if (b != 0) chk("busy_cycles", 64'(cyc - acc_cyc), 64'(b));
                    end
                end
                prev_rdy = snoop_ready;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", 64'({snoop_ready, tag_req, result_valid, wb_valid, wb_last, data_rd_en, state_wr_en, protocol_error}), 64'h80);
        chk("reset_wb_bus", {wb_addr, wb_data}, 64'd0);
        chk("reset_fields", 64'({tag_index, snoop_result, data_rd_addr, state_wr_way, state_wr_val}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        res(R_NO, 1'b0);
        issue(C_RD, 32'h0000_1040, 1'b0, 3'd0, M_I, 3);

        res(R_HIT, 1'b0); sw(3'd5, M_S);
        issue(C_RD, 32'h0000_3000, 1'b1, 3'd5, M_E, 4);

        res(R_HITM, 1'b0); line(32'h0000_2088, 3'd2); sw(3'd2, M_I);
        issue(C_RFO, 32'h0000_2088, 1'b1, 3'd2, M_M, 20);

        tog = 1'b1;
        res(R_HITM, 1'b0); line(32'h0000_2088, 3'd2); sw(3'd2, M_I);
        issue(C_RFO, 32'h0000_2088, 1'b1, 3'd2, M_M, 0);
        tog = 1'b0;

        res(R_HIT, 1'b1);
        issue(C_INV, 32'h0000_4000, 1'b1, 3'd1, M_M, 3);

        res(R_HIT, 1'b0);
        issue(C_WR, 32'h0000_5040, 1'b1, 3'd3, M_S, 4);

        res(R_HIT, 1'b0); sw(3'd4, M_I);
        issue(C_INV, 32'h0000_6080, 1'b1, 3'd4, M_S, 4);

        res(R_HITM, 1'b0); line(32'h0012_3450, 3'd6); sw(3'd6, M_S);
        issue(C_RD, 32'h0012_3450, 1'b1, 3'd6, M_M, 20);

        res(R_HIT, 1'b1);
        issue(C_WR, 32'h0000_7000, 1'b1, 3'd1, M_E, 3);

        res(R_NO, 1'b0);
        issue(C_RD, 32'h0000_8000, 1'b1, 3'd2, M_I, 3);

        res(R_HIT, 1'b0); sw(3'd0, M_I);
        issue(C_RFO, 32'h0000_9040, 1'b1, 3'd0, M_S, 4);

        base = wb_acc;
        res(R_HITM, 1'b0); line(32'h0005_5104, 3'd3); sw(3'd3, M_I);
        drive(C_RFO, 32'h0005_5104, 1'b1, 3'd3, M_M, 20);
        n = 0;
        while (wb_acc < base + 7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("beats_before_reset", 64'(wb_acc - base), 64'd7);
        chk("beat7_presented", 64'(wb_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_wb_valid", 64'(wb_valid), 64'd0);
        chk("async_reset_ready", 64'(snoop_ready), 64'd1);
        chk("async_reset_state_wr", 64'(state_wr_en), 64'd0);
        exp_wb.delete(); exp_sw.delete(); exp_busy.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("ready_after_reset", 64'(snoop_ready), 64'd1);
        @(posedge clk); #1;

        res(R_HIT, 1'b0); sw(3'd7, M_S);
        issue(C_RD, 32'h0000_A0C0, 1'b1, 3'd7, M_S, 4);

        repeat (5) @(posedge clk);
        #1;
        chk("left_results", 64'(exp_res.size()), 64'd0);
        chk("left_state_writes", 64'(exp_sw.size()), 64'd0);
        chk("left_wb_beats", 64'(exp_wb.size()), 64'd0);
        chk("left_busy", 64'(exp_busy.size()), 64'd0);
        chk("left_tag_req", 64'(exp_idx.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
